// File: rtl/imem_arbiter_if.sv
// Request/response bundle between the fetch/debug requesters, the arbiter and
// the combinational instruction memory read port.
interface imem_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_err;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport slave (
        input  fetch_req, fetch_addr, dbg_req, dbg_addr, mem_data,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
               dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err, mem_addr
    );

    modport master (
        output fetch_req, fetch_addr, dbg_req, dbg_addr, mem_data,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
               dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err, mem_addr
    );
endinterface

// File: rtl/imem_arbiter.sv
// Fetch-priority arbiter for the single-port instruction memory; debug is
// forced through after MAX_WAIT consecutive losses. One-cycle registered reads.
module imem_arbiter #(
    parameter int                ADDR_W   = 30,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] BASE     = 30'h00100000,
    parameter int                DEPTH    = 257,
    parameter int                MAX_WAIT = 4
) (
    input logic           clk,
    input logic           reset_n,
    imem_arbiter_if.slave bus
);
    localparam int                WC_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0]   WAIT_MAX = WC_W'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } resp_t;

    logic [WC_W-1:0]   wait_cnt;
    logic              fetch_gnt, dbg_gnt, in_range;
    logic [ADDR_W-1:0] mem_addr, off;
    resp_t             cap, fetch_resp, dbg_resp;
    logic              fetch_rvalid, dbg_rvalid;

    always_comb begin
        dbg_gnt   = bus.dbg_req && (!bus.fetch_req || wait_cnt == WAIT_MAX);
        fetch_gnt = bus.fetch_req && !dbg_gnt;
        mem_addr  = dbg_gnt ? bus.dbg_addr : bus.fetch_addr;
        // offset only meaningful when addr >= BASE, so no wrap can slip through
        off       = mem_addr - BASE;
        in_range  = (mem_addr >= BASE) && (off < DEPTH_A);
        cap.rdata = in_range ? bus.mem_data : '0;
        cap.err   = !in_range;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (bus.dbg_req && !dbg_gnt) begin
            wait_cnt <= (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WC_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_rvalid <= 1'b0;
            dbg_rvalid   <= 1'b0;
            fetch_resp   <= '0;
            dbg_resp     <= '0;
        end else begin
            fetch_rvalid <= fetch_gnt;
            dbg_rvalid   <= dbg_gnt;
            if (fetch_gnt) fetch_resp <= cap;
            if (dbg_gnt)   dbg_resp   <= cap;
        end
    end

    assign bus.fetch_gnt    = fetch_gnt;
    assign bus.dbg_gnt      = dbg_gnt;
    assign bus.mem_addr     = mem_addr;
    assign bus.fetch_rvalid = fetch_rvalid;
    assign bus.fetch_rdata  = fetch_resp.rdata;
    assign bus.fetch_err    = fetch_resp.err;
    assign bus.dbg_rvalid   = dbg_rvalid;
    assign bus.dbg_rdata    = dbg_resp.rdata;
    assign bus.dbg_err      = dbg_resp.err;
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter that shares the single-port, word-addressed instruction memory between the CPU fetch stage and a debug/loader port. The fetch stage has default priority. The debug port has starvation protection. Each granted request returns one registered read response a fixed one cycle later, with an out-of-range error flag. The block sits between the fetch/debug requesters and the combinational instruction memory read port.

## Interface
- ADDR_W, 30, word-address width
- DATA_W, 32, instruction word width
- BASE, 30'h00100000, lowest valid word address
- DEPTH, 257, number of valid words (BASE..BASE+DEPTH-1)
- MAX_WAIT, 4, consecutive lost cycles before debug is forced to win
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch read request; hold with stable fetch_addr until granted
- fetch_addr  in  ADDR_W  fetch word address
- fetch_gnt  out  1  combinational grant to fetch this cycle
- fetch_rvalid  out  1  registered, 1-cycle pulse: fetch_rdata/fetch_err valid
- fetch_rdata  out  DATA_W  fetch read data
- fetch_err  out  1  granted fetch address was out of range
- dbg_req, dbg_addr, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err: same as the fetch_* ports, for the debug port
- mem_addr  out  ADDR_W  address to the instruction memory read port
- mem_data  in  DATA_W  combinational memory read data for mem_addr

## Operation
- At most one grant per cycle. A grant completes a request; the requester may present a new address in the next cycle.
- Arbitration, evaluated combinationally each cycle:
  - Only one requester has req=1: it is granted.
  - Both have req=1 and wait_cnt < MAX_WAIT: fetch is granted.
  - Both have req=1 and wait_cnt == MAX_WAIT: debug is granted.
- wait_cnt, 0..MAX_WAIT, saturating:
  - Cycle with dbg_req=1 and no debug grant: increment, saturating at MAX_WAIT.
  - Debug grant: clear to 0.
  - dbg_req=0: clear to 0.
- mem_addr equals the granted requester's address. With no grant, mem_addr = fetch_addr.
- Range check: in_range = (addr >= BASE) && (addr - BASE < DEPTH), computed in ADDR_W-bit unsigned arithmetic with no wrap.
  - Out of range: rdata captured as 0 and err=1.
  - In range: rdata = mem_data and err=0.
- Response capture, on the rising edge after a grant:
  - The granted side's rvalid=1 and its rdata/err are loaded.
  - The other side's rvalid=0; its rdata/err hold their previous values.
- A side with no grant in the previous cycle has rvalid=0; its rdata/err hold.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req and wait_cnt.
- Read latency is 1 cycle: rvalid rises on the first rising edge after the gnt cycle.
- Throughput is one read per cycle total across both ports. Back-to-back grants to the same port yield back-to-back rvalid pulses.
- Worst-case debug wait under continuous fetch traffic is MAX_WAIT lost cycles; the grant comes in cycle MAX_WAIT+1.
- Reset values: fetch_rvalid = dbg_rvalid = 0, fetch_rdata = dbg_rdata = 0, fetch_err = dbg_err = 0, wait_cnt = 0.
  - fetch_gnt, dbg_gnt and mem_addr are combinational and follow the inputs even while reset_n=0.
  - While reset_n=0, no capture occurs.
- Reset mid-operation: asserting reset_n=0 in the cycle after a grant clears the pending rvalid immediately. The response is lost, and the requester must re-request.
- Dropping req before a grant is legal; no response is generated.
- Changing addr while req=1 and not granted is legal; the address sampled in the grant cycle is used.

## Test plan
- Reset then idle:
  - Stimulus: reset_n=0 for 2 cycles, release, no req.
  - Required: all rvalid/rdata/err = 0, both gnt = 0, mem_addr = fetch_addr.
- Single fetch:
  - Stimulus: fetch_req=1 with fetch_addr=30'h00100004, memory word there = 32'h2402000A.
  - Required: fetch_gnt=1 the same cycle; next cycle fetch_rvalid=1, fetch_rdata=32'h2402000A, fetch_err=0.
- Starvation limit:
  - Stimulus: fetch_req and dbg_req both held high, MAX_WAIT=4.
  - Required: fetch granted in cycles 1-4; debug granted in cycle 5 and wait_cnt returns to 0; fetch granted again in cycle 6.
- Range boundaries:
  - Stimulus: debug reads at 30'h00100100 (last valid), 30'h00100101, and 30'h000FFFFF.
  - Required: first returns the memory word with err=0; the other two return rdata=0 with dbg_err=1.
- Alternating back-to-back:
  - Stimulus: fetch alone, then debug alone, then fetch alone, in consecutive cycles.
  - Required: rvalid pulses alternate fetch/dbg/fetch on consecutive cycles; the non-granted side's rdata holds its value.
- Reset mid-flight:
  - Stimulus: grant fetch, then pull reset_n=0 before the next rising edge.
  - Required: fetch_rvalid never rises; after release, wait_cnt = 0 and fetch is granted on re-request.
